rxm_capture_ctrl: RTL and testbench
===================================

Name: rxm_capture_ctrl

Overview:
Sequences receiver-module sample capture into the mSGDMA Avalon-ST sink (64-bit data, valid/ready) of the system.
- Packs pairs of 32-bit samples into 64-bit words and buffers them in a small FIFO against sink backpressure.
- Stops after a programmed word count, then reports completion.
- Sits between the RXM sample front end and msgdma_rxm_st_sink_*. It is configured by software through a PIO/CSR wrapper.

Parameters:
- CNT_W, 24, width of word-count and sent-count fields.
- FIFO_DEPTH, 16, 64-bit word FIFO depth; power of two, minimum 4.

Ports:
- clk  in  1  system clock (sys_clk domain).
- reset  in  1  asynchronous, active-high reset.
- cfg_start  in  1  one-cycle pulse; arms a capture.
- cfg_abort  in  1  one-cycle pulse; terminates a capture.
- cfg_word_count  in  CNT_W  number of 64-bit words per capture; sampled on cfg_start.
- samp_data  in  32  RXM sample.
- samp_valid  in  1  sample qualifier; no backpressure to the front end.
- trig_in  in  1  external trigger level; used only with RXM_TRIGGER_EN.
- st_data  out  64  to msgdma_rxm_st_sink_data.
- st_valid  out  1  to msgdma_rxm_st_sink_valid.
- st_ready  in  1  from msgdma_rxm_st_sink_ready.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on successful completion.
- overflow  out  1  sticky; set when a packed word is dropped.
- words_sent  out  CNT_W  st handshakes completed in the current or last capture.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, FIFO empty, pack phase 0.
- FSM states:
  - IDLE -> CAPTURE on cfg_start when cfg_word_count != 0. cfg_start with count 0 is ignored. cfg_start in any non-IDLE state is ignored.
  - On the IDLE -> CAPTURE transition: latch the count, clear words_sent, overflow, the packed-word counter and the pack phase.
  - CAPTURE: accept samples when samp_valid=1. Phase 0 stores samp_data into st word [31:0]. Phase 1 completes the word with samp_data in [63:32] and issues a write.
  - Write rules: the write is enqueued if the FIFO is not full. Otherwise it is dropped and overflow is set. Either way the packed-word counter increments.
  - CAPTURE -> DRAIN when the packed-word counter reaches the latched count. Samples arriving in the same cycle as the final write, and all later samples, are discarded.
  - DRAIN -> DONE when the FIFO is empty and no word is outstanding.
  - DONE: done=1 for one cycle, then IDLE.
  - A half-packed word is never emitted.
- Abort: cfg_abort in CAPTURE or DRAIN flushes the FIFO, clears st_valid next cycle and goes to IDLE. done is not pulsed; words_sent holds its value. If cfg_start and cfg_abort coincide, abort wins.
- Stream handshake:
  - st_valid = FIFO not empty, driven from the registered FIFO head.
  - A word transfers when st_valid and st_ready are both 1, which pops the FIFO and increments words_sent.
  - st_data is stable while st_valid=1 and st_ready=0.
- Latency: the completing (phase-1) sample in cycle N gives st_valid=1 in cycle N+2 when the FIFO was empty.
- FIFO: a write and a pop in the same cycle at full is accepted, with no overflow. Occupancy wraps modulo FIFO_DEPTH using pointers one bit wider.
- Counters: words_sent saturates at 2^CNT_W-1 and cannot exceed the latched count by construction.

Optional Feature:
RXM_TRIGGER_EN
- Defined: adds state ARMED between IDLE and CAPTURE. cfg_start enters ARMED with busy=1. A rising edge of trig_in (registered, 0->1 across consecutive cycles) moves the FSM to CAPTURE, and the first accepted sample is the one in the cycle after the edge is detected. cfg_abort in ARMED returns the FSM to IDLE.
- Undefined: trig_in is ignored and unconnected internally, and cfg_start goes directly to CAPTURE.

Decomposition:
- Package rxm_capture_pkg: FSM state enum (IDLE, ARMED, CAPTURE, DRAIN, DONE), constants SAMP_W=32 and ST_W=64, and the FIFO pointer width function.
- Sub-module rxm_sc_fifo: single-clock, show-ahead, registered-head FIFO with full/empty flags and a flush input.

Test Plan:
- Count=4, continuous samples 0x1..0x8, st_ready=1:
  - Four words are emitted: 0x00000002_00000001 through 0x00000008_00000007.
  - done pulses once; words_sent=4; overflow=0.
- Count=32, st_ready=0 throughout capture:
  - 16 words are buffered and 16 are dropped; overflow=1.
  - Then st_ready=1: 16 words drain, done pulses, words_sent=16.
- st_ready toggled 1/0 every cycle with count=8: st_data is held while stalled, all 8 words arrive in order, and words_sent=8.
- Abort asserted after 3 of 10 words are sent:
  - st_valid=0 next cycle and the FIFO is empty.
  - No done pulse; words_sent=3; busy=0.
- Edge cases:
  - cfg_start with count=0 leaves busy=0.
  - cfg_start while busy is ignored.
  - Simultaneous start and abort in IDLE stays in IDLE.
  - reset mid-capture returns all outputs to 0.
- With RXM_TRIGGER_EN: samples before the trig_in rising edge are ignored. The first word equals {sample at edge+2, sample at edge+1}.

Source files
------------

// File: rtl/rxm_capture_pkg.sv
// Shared types and constants for the RXM capture controller.
// States, bus widths and the FIFO pointer-width helper.
package rxm_capture_pkg;

  localparam int SAMP_W = 32;
  localparam int ST_W   = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // One extra bit distinguishes full from empty.
  function automatic int fifo_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/rxm_capture_ctrl_fifo.sv
// Single-clock show-ahead FIFO with flush; head word is read from
// the register array. Instantiated as rxm_sc_fifo.
module rxm_sc_fifo
  import rxm_capture_pkg::*;
#(
  parameter int DW    = 64,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush_i,
  input  logic          wr_en_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          rd_en_i,
  output logic [DW-1:0] rd_data_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = fifo_ptr_w(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic          do_wr, do_rd;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);

  // A pop frees the slot a same-cycle write at full lands in.
  assign do_rd = rd_en_i && !empty_o;
  assign do_wr = wr_en_i && (!full_o || do_rd);

  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_rd) rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_wr && !flush_i) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
  end

endmodule

// File: rtl/rxm_capture_ctrl.sv
// RXM sample capture sequencer: packs sample pairs into 64-bit words
// for the mSGDMA stream sink. Define RXM_TRIGGER_EN for trigger arming.
module rxm_capture_ctrl
  import rxm_capture_pkg::*;
#(
  parameter int CNT_W      = 24,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_start,
  input  logic              cfg_abort,
  input  logic [CNT_W-1:0]  cfg_word_count,
  input  logic [SAMP_W-1:0] samp_data,
  input  logic              samp_valid,
  input  logic              trig_in,
  output logic [ST_W-1:0]   st_data,
  output logic              st_valid,
  input  logic              st_ready,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [CNT_W-1:0]  words_sent
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  pack_q, pack_d;
  logic [CNT_W-1:0]  sent_q, sent_d;
  logic              phase_q, phase_d;
  logic [SAMP_W-1:0] lo_q, lo_d;
  logic [ST_W-1:0]   word_q, word_d;
  logic              wr_q, wr_d;
  logic              ovf_q, ovf_d;

  logic fifo_full, fifo_empty;
  logic pop, abort_act, start_ok;
  logic accept, last, trig_edge;

`ifdef RXM_TRIGGER_EN
  localparam state_e START_ST = ST_ARMED;
  logic trig_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) trig_q <= 1'b0;
    else       trig_q <= trig_in;
  end

  assign trig_edge = trig_in && !trig_q;
`else
  localparam state_e START_ST = ST_CAPTURE;
  logic unused_trig;

  assign unused_trig = trig_in;
  assign trig_edge   = 1'b0;
`endif

  assign st_valid = !fifo_empty;
  assign pop      = st_valid && st_ready;

  assign abort_act = cfg_abort &&
    (state_q inside {ST_ARMED, ST_CAPTURE, ST_DRAIN});

  assign start_ok = (state_q == ST_IDLE) && cfg_start &&
                    !cfg_abort && (cfg_word_count != '0);

  assign accept = (state_q == ST_CAPTURE) && samp_valid && !cfg_abort;
  assign last   = accept && phase_q &&
                  ((pack_q + CNT_W'(1)) == cnt_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pack_d  = pack_q;
    sent_d  = sent_q;
    phase_d = phase_q;
    lo_d    = lo_q;
    word_d  = word_q;
    wr_d    = 1'b0;
    ovf_d   = ovf_q;

    if (pop && (sent_q != '1)) sent_d = sent_q + CNT_W'(1);
    // Word arriving with the FIFO full and nothing leaving is lost.
    if (wr_q && fifo_full && !pop && !abort_act) ovf_d = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d = START_ST;
          cnt_d   = cfg_word_count;
          pack_d  = '0;
          phase_d = 1'b0;
          sent_d  = '0;
          ovf_d   = 1'b0;
        end
      end
      ST_ARMED: begin
        if (abort_act)      state_d = ST_IDLE;
        else if (trig_edge) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (abort_act) begin
          state_d = ST_IDLE;
        end else if (accept) begin
          if (!phase_q) begin
            lo_d    = samp_data;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            word_d  = {samp_data, lo_q};
            wr_d    = 1'b1;
            pack_d  = pack_q + CNT_W'(1);
            if (last) state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (abort_act)                 state_d = ST_IDLE;
        else if (fifo_empty && !wr_q) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pack_q  <= '0;
      sent_q  <= '0;
      phase_q <= 1'b0;
      lo_q    <= '0;
      word_q  <= '0;
      wr_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pack_q  <= pack_d;
      sent_q  <= sent_d;
      phase_q <= phase_d;
      lo_q    <= lo_d;
      word_q  <= word_d;
      wr_q    <= wr_d;
      ovf_q   <= ovf_d;
    end
  end

  rxm_sc_fifo #(
    .DW    (ST_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush_i   (abort_act),
    .wr_en_i   (wr_q),
    .wr_data_i (word_q),
    .rd_en_i   (st_ready),
    .rd_data_o (st_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign overflow   = ovf_q;
  assign words_sent = sent_q;

endmodule

// File: tb/tb_rxm_capture_ctrl.sv
// Directed bench for rxm_capture_ctrl with hand-computed words.
// Trigger check is built only with RXM_TRIGGER_EN.
module tb_rxm_capture_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_start, cfg_abort;
  logic [23:0] cfg_word_count;
  logic [31:0] samp_data;
  logic        samp_valid, trig_in;
  logic [63:0] st_data;
  logic        st_valid, st_ready;
  logic        busy, done, overflow;
  logic [23:0] words_sent;

  int          n_cmp  = 0;
  int          n_bad  = 0;
  int          n_done = 0;
  logic        tog    = 1'b0;
  logic        stall_q = 1'b0;
  logic [63:0] held_q = '0;
  logic [63:0] got[$];

  always #5 clk = ~clk;

  rxm_capture_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_start      (cfg_start),
    .cfg_abort      (cfg_abort),
    .cfg_word_count (cfg_word_count),
    .samp_data      (samp_data),
    .samp_valid     (samp_valid),
    .trig_in        (trig_in),
    .st_data        (st_data),
    .st_valid       (st_valid),
    .st_ready       (st_ready),
    .busy           (busy),
    .done           (done),
    .overflow       (overflow),
    .words_sent     (words_sent)
  );

  task automatic check(input string tag,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (stall_q && st_valid) check("hold", st_data, held_q);
      if (done) n_done++;
      if (st_valid && st_ready) got.push_back(st_data);
    end
    stall_q = st_valid && !st_ready && !reset;
    held_q  = st_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (tog) st_ready = ~st_ready;
  endtask

  task automatic idle_wait(input int budget);
    for (int i = 0; i < budget && busy; i++) tick();
    check("idle_to", 64'(busy), 64'd0);
  endtask

  task automatic start(input logic [23:0] n);
    cfg_word_count = n;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic feed(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      samp_data  = 32'(first + i);
      samp_valid = 1'b1;
      tick();
    end
    samp_valid = 1'b0;
  endtask

  task automatic clr();
    got.delete();
    n_done = 0;
  endtask

  function automatic logic [63:0] wd(input int k);
    return {32'(2 * k + 2), 32'(2 * k + 1)};
  endfunction

  initial begin
    reset = 1'b1;
    cfg_start = 1'b0;
    cfg_abort = 1'b0;
    cfg_word_count = '0;
    samp_data = '0;
    samp_valid = 1'b0;
    trig_in = 1'b0;
    st_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("rst_valid", 64'(st_valid), 64'd0);
    check("rst_data", st_data, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_sent", 64'(words_sent), 64'd0);

    // count 4, ready high, with first-word latency
    clr();
    st_ready = 1'b1;
    start(24'd4);
    for (int i = 1; i <= 8; i++) begin
      samp_data  = 32'(i);
      samp_valid = 1'b1;
      tick();
      if (i == 2) check("lat_n1", 64'(st_valid), 64'd0);
      if (i == 3) begin
        check("lat_n2", 64'(st_valid), 64'd1);
        check("lat_data", st_data, wd(0));
      end
    end
    samp_valid = 1'b0;
    idle_wait(40);
    check("t1_n", 64'(got.size()), 64'd4);
    for (int k = 0; k < 4; k++) check("t1_word", got[k], wd(k));
    check("t1_done", 64'(n_done), 64'd1);
    check("t1_sent", 64'(words_sent), 64'd4);
    check("t1_ovf", 64'(overflow), 64'd0);

    // count 32 with sink stalled: half the words overflow
    clr();
    st_ready = 1'b0;
    start(24'd32);
    feed(1, 64);
    tick();
    tick();
    check("t2_ovf", 64'(overflow), 64'd1);
    check("t2_valid", 64'(st_valid), 64'd1);
    check("t2_busy", 64'(busy), 64'd1);
    check("t2_sent0", 64'(words_sent), 64'd0);
    st_ready = 1'b1;
    idle_wait(60);
    check("t2_n", 64'(got.size()), 64'd16);
    check("t2_first", got[0], wd(0));
    check("t2_last", got[15], wd(15));
    check("t2_sent", 64'(words_sent), 64'd16);
    check("t2_done", 64'(n_done), 64'd1);

    // ready toggling every cycle
    clr();
    st_ready = 1'b0;
    tog = 1'b1;
    start(24'd8);
    feed(1, 16);
    idle_wait(60);
    tog = 1'b0;
    check("t3_n", 64'(got.size()), 64'd8);
    for (int k = 0; k < 8; k++) check("t3_word", got[k], wd(k));
    check("t3_sent", 64'(words_sent), 64'd8);
    check("t3_ovf", 64'(overflow), 64'd0);

    // abort after 3 of 10 words sent
    clr();
    st_ready = 1'b0;
    start(24'd10);
    feed(1, 20);
    tick();
    tick();
    st_ready = 1'b1;
    tick();
    tick();
    tick();
    st_ready = 1'b0;
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    check("t4_valid", 64'(st_valid), 64'd0);
    check("t4_busy", 64'(busy), 64'd0);
    tick();
    tick();
    check("t4_sent", 64'(words_sent), 64'd3);
    check("t4_done", 64'(n_done), 64'd0);
    check("t4_n", 64'(got.size()), 64'd3);
    check("t4_valid2", 64'(st_valid), 64'd0);

    // zero count, start+abort in idle
    clr();
    start(24'd0);
    check("zero_busy", 64'(busy), 64'd0);
    cfg_word_count = 24'd5;
    cfg_start = 1'b1;
    cfg_abort = 1'b1;
    tick();
    cfg_start = 1'b0;
    cfg_abort = 1'b0;
    check("sa_busy", 64'(busy), 64'd0);

    // second start while busy is ignored
    st_ready = 1'b1;
    start(24'd2);
    cfg_word_count = 24'd100;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    check("rs_busy", 64'(busy), 64'd1);
    feed(32'h11, 4);
    idle_wait(40);
    check("rs_sent", 64'(words_sent), 64'd2);
    check("rs_n", 64'(got.size()), 64'd2);
    check("rs_word", got[1], 64'h00000014_00000013);
    check("rs_done", 64'(n_done), 64'd1);

    // reset in mid-capture
    clr();
    st_ready = 1'b1;
    start(24'd8);
    feed(1, 6);
    tick();
    tick();
    st_ready = 1'b0;
    feed(7, 2);
    tick();
    tick();
    check("mr_sent", 64'(words_sent), 64'd3);
    check("mr_valid", 64'(st_valid), 64'd1);
    check("mr_data", st_data, wd(3));
    reset = 1'b1;
    #2;
    check("mr_rvalid", 64'(st_valid), 64'd0);
    check("mr_rdata", st_data, 64'd0);
    check("mr_rbusy", 64'(busy), 64'd0);
    check("mr_rsent", 64'(words_sent), 64'd0);
    check("mr_rdone", 64'(done), 64'd0);
    check("mr_rovf", 64'(overflow), 64'd0);
    tick();
    reset = 1'b0;
    tick();

`ifdef RXM_TRIGGER_EN
    clr();
    st_ready = 1'b1;
    start(24'd1);
    check("tg_busy", 64'(busy), 64'd1);
    for (int k = 0; k < 8; k++) begin
      samp_data  = 32'h0A0 + 32'(k);
      samp_valid = 1'b1;
      trig_in    = (k >= 3);
      tick();
    end
    samp_valid = 1'b0;
    trig_in = 1'b0;
    idle_wait(40);
    check("tg_n", 64'(got.size()), 64'd1);
    check("tg_word", got[0], 64'h000000A5_000000A4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
